tlul_outstanding_limiter: RTL

TLUL_OUTSTANDING_LIMITER -- requirements
Module: tlul_outstanding_limiter

---
 rtl/tlul_pkg.sv | 51 +++++
 rtl/tlul_outstanding_limiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/tlul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlul_pkg
// Description : TileLink-UL (TL-UL) channel types shared by the bus blocks:
//               host-to-device A/D-ready bundle and device-to-host D/A-ready
//               bundle, plus the opcode encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package tlul_pkg;

    localparam int unsigned c_TL_AW  = 32;
    localparam int unsigned c_TL_DW  = 32;
    localparam int unsigned c_TL_SZW = 2;
    localparam int unsigned c_TL_AIW = 8;
    localparam int unsigned c_TL_DBW = c_TL_DW / 8;

    // A-channel opcodes
    localparam logic [2:0] c_PUT_FULL_DATA    = 3'h0;
    localparam logic [2:0] c_PUT_PARTIAL_DATA = 3'h1;
    localparam logic [2:0] c_GET              = 3'h4;

    // D-channel opcodes
    localparam logic [2:0] c_ACCESS_ACK       = 3'h0;
    localparam logic [2:0] c_ACCESS_ACK_DATA  = 3'h1;

    typedef struct packed {
        logic                a_valid;
        logic [2:0]          a_opcode;
        logic [2:0]          a_param;
        logic [c_TL_SZW-1:0] a_size;
        logic [c_TL_AIW-1:0] a_source;
        logic [c_TL_AW-1:0]  a_address;
        logic [c_TL_DBW-1:0] a_mask;
        logic [c_TL_DW-1:0]  a_data;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        logic [2:0]          d_opcode;
        logic [2:0]          d_param;
        logic [c_TL_SZW-1:0] d_size;
        logic [c_TL_AIW-1:0] d_source;
        logic                d_sink;
        logic [c_TL_DW-1:0]  d_data;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

endpackage
`default_nettype wire

// File: rtl/tlul_outstanding_limiter.sv
`default_nettype none
// ============================================================================
// Module      : tlul_outstanding_limiter
// Description : Caps the number of accepted-but-unanswered TL-UL A requests,
//               supports a drain handshake for quiescing the link, and flags
//               response timeouts and unsolicited D responses (both sticky).
// Revision    : 1.0 - initial release
// ============================================================================
module tlul_outstanding_limiter
    import tlul_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  tl_h2d_t                              tl_h_i,
    output tl_d2h_t                              tl_h_o,
    output tl_h2d_t                              tl_d_o,
    input  tl_d2h_t                              tl_d_i,
    input  logic                                 drain_req_i,
    output logic                                 drain_ack_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
    output logic                                 timeout_o,
    output logic                                 proto_err_o
);

    localparam int unsigned c_CNT_W = $clog2(MaxOutstanding + 1);
    localparam int unsigned c_WD_W  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MaxOutstanding);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ACTIVE   = 2'd0,
        DRAINING = 2'd1,
        DRAINED  = 2'd2
    } state_e;

    state_e             r_state;
    logic               r_drain_ack;
    logic [c_CNT_W-1:0] r_count;
    logic               r_hold;
    logic               r_proto_err;

    logic w_pass;
    logic w_a_valid_dn;
    logic w_a_ready_up;
    logic w_a_hs;
    logic w_d_hs;

    // Gate the A channel from registered state only, so no D-channel signal
    // can reach an A-channel output. A request already offered downstream
    // (hold) keeps passing until it completes, even if the limit or a drain
    // would otherwise close the gate.
    assign w_pass       = ((r_state == ACTIVE) && (r_count < c_CNT_MAX)) || r_hold;
    assign w_a_valid_dn = tl_h_i.a_valid & w_pass;
    assign w_a_ready_up = tl_d_i.a_ready & w_pass;
    assign w_a_hs       = w_a_valid_dn & tl_d_i.a_ready;
    assign w_d_hs       = tl_d_i.d_valid & tl_h_i.d_ready;

    // Payload and D channel pass straight through; only the A handshake pair is gated
    always_comb begin
        tl_d_o         = tl_h_i;
        tl_d_o.a_valid = w_a_valid_dn;
        tl_h_o         = tl_d_i;
        tl_h_o.a_ready = w_a_ready_up;
    end

    // Remember that a request has been offered downstream until it is taken
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hold <= 1'b0;
        end else if (w_a_hs) begin
            r_hold <= 1'b0;
        end else if (w_a_valid_dn) begin
            r_hold <= 1'b1;
        end
    end

    // Outstanding count; a response with nothing outstanding is flagged, not counted
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_a_hs && !w_d_hs) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_d_hs && !w_a_hs && (r_count != '0)) begin
                r_count <= r_count - c_CNT_ONE;
            end
            if (w_d_hs && (r_count == '0)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    generate
        if (TimeoutCycles == 0) begin : g_no_watchdog
            assign timeout_o = 1'b0;
        end else begin : g_watchdog
            localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TimeoutCycles - 1);
            localparam logic [c_WD_W-1:0] c_WD_ONE  = c_WD_W'(1);

            logic [c_WD_W-1:0] r_wd;
            logic              r_timeout;

            // Count cycles without response progress; saturate and flag on expiry
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_wd      <= '0;
                    r_timeout <= 1'b0;
                end else if ((r_count == '0) || w_d_hs) begin
                    r_wd <= '0;
                end else if (r_wd == c_WD_LAST) begin
                    r_timeout <= 1'b1;
                end else begin
                    r_wd <= r_wd + c_WD_ONE;
                end
            end

            assign timeout_o = r_timeout;
        end
    endgenerate

    // Drain state machine with registered acknowledge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ACTIVE;
            r_drain_ack <= 1'b0;
        end else begin
            r_drain_ack <= 1'b0;
            case (r_state)
                ACTIVE: begin
                    if (drain_req_i) begin
                        r_state <= DRAINING;
                    end
                end
                DRAINING: begin
                    if (!drain_req_i) begin
                        r_state <= ACTIVE;
                    end else if ((r_count == '0) && !r_hold) begin
                        r_state     <= DRAINED;
                        r_drain_ack <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!drain_req_i) begin
                        r_state <= ACTIVE;
                    end else begin
                        r_drain_ack <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ACTIVE;
                end
            endcase
        end
    end

    assign drain_ack_o   = r_drain_ack;
    assign outstanding_o = r_count;
    assign proto_err_o   = r_proto_err;

endmodule
`default_nettype wire
